wb_sdblk: RTL

Wishbone-slave block-device controller that drives the hps_io virtual-disk request interface (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) for one mounted image (VD slot 0). The CPU sets an LBA, starts a 512-byte sector read or write, and reads or fills a memory-mapped sector buffer. The block sits on the I/O MMU (mmu_bus2) alongside the uart, timer and ps2 peripherals. Its irq output feeds interrupt_encoder.

---
 rtl/sdblk_pkg.sv | 22 ++
 rtl/sdblk_buf.sv | 61 ++++++
 rtl/wb_sdblk.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sdblk_pkg.sv
// Shared types and constants for the Wishbone virtual-disk block controller.
package sdblk_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StXfer} sd_state_e;

  localparam logic [6:0] RegCtrl = 7'd0;
  localparam logic [6:0] RegLba  = 7'd1;
  localparam logic [6:0] RegSize = 7'd2;

  localparam int unsigned CtrlStartRd = 0;
  localparam int unsigned CtrlStartWr = 1;
  localparam int unsigned CtrlClear   = 2;

  localparam int unsigned StatBusy     = 0;
  localparam int unsigned StatDone     = 1;
  localparam int unsigned StatErr      = 2;
  localparam int unsigned StatMounted  = 3;
  localparam int unsigned StatReadonly = 4;

  localparam int unsigned SECTOR_BYTES = 512;

endpackage

// File: rtl/sdblk_buf.sv
// Sector buffer: byte-wide HPS port and 32-bit sel-masked CPU port over four 128x8 lanes.
module sdblk_buf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [8:0]  hps_addr_i,
  input  logic [7:0]  hps_wdata_i,
  input  logic        hps_we_i,
  output logic [7:0]  hps_rdata_o,
  input  logic [6:0]  cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic        cpu_we_i,
  output logic [31:0] cpu_rdata_o
);

  logic [7:0] hps_lane_rd [4];
  logic [1:0] hps_lane_q;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    // Big-endian: lane 0 (byte 4w+0) lives on dat[31:24].
    localparam int unsigned Msb = 31 - 8 * l;

    logic [7:0] mem [128];
    logic [7:0] cpu_q;
    logic [7:0] hps_q;
    logic       hps_hit;
    logic       cpu_hit;

    assign hps_hit = hps_we_i && (hps_addr_i[1:0] == 2'(l));
    assign cpu_hit = cpu_we_i && cpu_sel_i[3-l];

    // HPS write is applied last so it wins a same-byte collision.
    always_ff @(posedge clk_i) begin
      if (cpu_hit) mem[cpu_addr_i] <= cpu_wdata_i[Msb -: 8];
      if (hps_hit) mem[hps_addr_i[8:2]] <= hps_wdata_i;
      cpu_q <= mem[cpu_addr_i];
    end

    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        hps_q <= 8'h00;
      end else begin
        hps_q <= mem[hps_addr_i[8:2]];
      end
    end

    assign cpu_rdata_o[Msb -: 8] = cpu_q;
    assign hps_lane_rd[l]        = hps_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      hps_lane_q <= 2'd0;
    end else begin
      hps_lane_q <= hps_addr_i[1:0];
    end
  end

  assign hps_rdata_o = hps_lane_rd[hps_lane_q];

endmodule

// File: rtl/wb_sdblk.sv
// Wishbone-slave block-device controller driving the hps_io virtual-disk request interface.
module wb_sdblk
  import sdblk_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32'd20000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  output logic        wb_err_o,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  output logic [7:0]  sd_buff_din,
  input  logic        sd_buff_wr,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  output logic        irq
);

  sd_state_e   state_q;
  logic        rd_q, wr_q;
  logic        done_q, err_q, mounted_q, ro_q;
  logic [31:0] size_q, lba_q, sd_lba_q, timer_q;

  logic        ack_q, region_q, reg_wr_q;
  logic [6:0]  wr_word_q;
  logic [31:0] wr_dat_q, reg_rdata_q, reg_rdata, buf_rdata;

  logic req, buf_sel, busy;
  logic cmd_wr, lba_wr, start_rd, start_wr, clear;
  logic unused_adr;

  assign req        = wb_cyc_i && wb_stb_i && !ack_q;
  assign buf_sel    = wb_adr_i[9];
  assign busy       = (state_q != StIdle);
  assign unused_adr = ^{wb_adr_i[31:10], wb_adr_i[1:0]};

  always_comb begin
    reg_rdata = 32'd0;
    if (wb_adr_i[8:2] == RegCtrl) begin
      reg_rdata[StatBusy]     = busy;
      reg_rdata[StatDone]     = done_q;
      reg_rdata[StatErr]      = err_q;
      reg_rdata[StatMounted]  = mounted_q;
      reg_rdata[StatReadonly] = ro_q;
    end else if (wb_adr_i[8:2] == RegLba) begin
      reg_rdata = lba_q;
    end else if (wb_adr_i[8:2] == RegSize) begin
      reg_rdata = size_q;
    end
  end

  // Register writes are latched at the request edge and take effect at the end of the ack cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ack_q       <= 1'b0;
      region_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      wr_word_q   <= 7'd0;
      wr_dat_q    <= 32'd0;
      reg_rdata_q <= 32'd0;
    end else begin
      ack_q    <= req;
      reg_wr_q <= req && wb_we_i && !buf_sel;
      if (req) begin
        region_q    <= buf_sel;
        wr_word_q   <= wb_adr_i[8:2];
        wr_dat_q    <= wb_dat_i;
        reg_rdata_q <= reg_rdata;
      end
    end
  end

  assign cmd_wr   = reg_wr_q && (wr_word_q == RegCtrl);
  assign lba_wr   = reg_wr_q && (wr_word_q == RegLba);
  assign start_rd = cmd_wr && wr_dat_q[CtrlStartRd];
  assign start_wr = cmd_wr && wr_dat_q[CtrlStartWr] && !wr_dat_q[CtrlStartRd];
  assign clear    = cmd_wr && wr_dat_q[CtrlClear];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mounted_q <= 1'b0;
      ro_q      <= 1'b0;
      size_q    <= 32'd0;
      lba_q     <= 32'd0;
      sd_lba_q  <= 32'd0;
      timer_q   <= 32'd0;
    end else begin
      if (img_mounted) begin
        mounted_q <= (img_size != 64'd0);
        ro_q      <= img_readonly;
        size_q    <= img_size[40:9];
      end
      if (lba_wr) lba_q <= wr_dat_q;
      if (clear) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (start_rd || start_wr) begin
            if (!mounted_q || (start_wr && ro_q)) begin
              err_q <= 1'b1;
            end else begin
              done_q   <= 1'b0;
              err_q    <= 1'b0;
              rd_q     <= start_rd;
              wr_q     <= start_wr;
              sd_lba_q <= lba_q;
              timer_q  <= 32'd0;
              state_q  <= StReq;
            end
          end
        end
        StReq: begin
          if (sd_ack) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= StXfer;
          end else if (timer_q == 32'(TIMEOUT - 1)) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        StXfer: begin
          if (!sd_ack) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Request drops combinationally in the cycle the acknowledge arrives.
  assign sd_rd  = rd_q && !sd_ack;
  assign sd_wr  = wr_q && !sd_ack;
  assign sd_lba = sd_lba_q;
  assign irq    = done_q || err_q;

  sdblk_buf u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .hps_addr_i  (sd_buff_addr),
    .hps_wdata_i (sd_buff_dout),
    .hps_we_i    (sd_buff_wr),
    .hps_rdata_o (sd_buff_din),
    .cpu_addr_i  (wb_adr_i[8:2]),
    .cpu_wdata_i (wb_dat_i),
    .cpu_sel_i   (wb_sel_i),
    .cpu_we_i    (req && wb_we_i && buf_sel),
    .cpu_rdata_o (buf_rdata)
  );

  assign wb_dat_o   = region_q ? buf_rdata : reg_rdata_q;
  assign wb_ack_o   = ack_q;
  assign wb_stall_o = 1'b0;
  assign wb_err_o   = 1'b0;

endmodule
